// File: rtl/lvt_multiport_ram.sv
// Multi-write, multi-read RAM: replicated banks plus a Live Value Table recording the last writer per address.
// Optional macro LVT_BYPASS_EN forwards same-cycle write data to matching reads.
module lvt_multiport_ram #(
    parameter int n_write     = 2,
    parameter int n_read      = 2,
    parameter int data_width  = 32,
    parameter int index_width = 6
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [n_write-1:0]              wen,
    input  logic [n_write*index_width-1:0]  waddr,
    input  logic [n_write*data_width-1:0]   wdata,
    input  logic [n_read-1:0]               ren,
    input  logic [n_read*index_width-1:0]   raddr,
    output logic [n_read*data_width-1:0]    rdata,
    output logic [n_read-1:0]               rvalid,
    output logic                            init_done,
    output logic                            wr_conflict
);

    localparam int depth     = 1 << index_width;
    localparam int lvt_width = (n_write > 1) ? $clog2(n_write) : 1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_r;
    logic [index_width-1:0]  init_cnt_r;
    logic [lvt_width-1:0]    lvt_r [depth];
    logic [data_width-1:0]   bank_r [n_write][n_read][depth];
    logic [data_width-1:0]   rdata_r [n_read];
    logic [n_read-1:0]       rvalid_r;
    logic                    init_done_r;
    logic                    wr_conflict_r;

    logic [index_width-1:0]  waddr_s [n_write];
    logic [data_width-1:0]   wdata_s [n_write];
    logic [index_width-1:0]  raddr_s [n_read];
    logic [n_write-1:0]      wen_eff_s;
    logic                    conflict_s;
    logic [data_width-1:0]   rd_word_s [n_read];

    // Unpack the flat port buses into per-port views
    always_comb begin
        for (int w = 0; w < n_write; w++) begin
            waddr_s[w] = waddr[w*index_width +: index_width];
            wdata_s[w] = wdata[w*data_width +: data_width];
        end
        for (int r = 0; r < n_read; r++) begin
            raddr_s[r] = raddr[r*index_width +: index_width];
        end
    end

    // Same-address collision: lowest-index enabled port wins, higher ports are suppressed
    always_comb begin
        wen_eff_s  = wen;
        conflict_s = 1'b0;
        for (int w = 1; w < n_write; w++) begin
            for (int v = 0; v < w; v++) begin
                if (wen[v] && wen[w] && (waddr_s[v] == waddr_s[w])) begin
                    wen_eff_s[w] = 1'b0;
                    conflict_s   = 1'b1;
                end else begin
                    wen_eff_s[w] = wen_eff_s[w];
                end
            end
        end
    end

    // Read mux: LVT picks the live bank; optional forwarding of this cycle's winning write
    always_comb begin
        for (int r = 0; r < n_read; r++) begin
            rd_word_s[r] = bank_r[0][r][raddr_s[r]];
            for (int w = 1; w < n_write; w++) begin
                if (lvt_r[raddr_s[r]] == lvt_width'(w)) begin
                    rd_word_s[r] = bank_r[w][r][raddr_s[r]];
                end else begin
                    rd_word_s[r] = rd_word_s[r];
                end
            end
`ifdef LVT_BYPASS_EN
            // Descending scan so the lowest-index matching write takes priority
            for (int w = n_write - 1; w >= 0; w--) begin
                if (wen_eff_s[w] && (waddr_s[w] == raddr_s[r])) begin
                    rd_word_s[r] = wdata_s[w];
                end else begin
                    rd_word_s[r] = rd_word_s[r];
                end
            end
`endif
        end
    end

    // Control FSM, LVT and registered read outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_INIT;
            init_cnt_r    <= '0;
            init_done_r   <= 1'b0;
            wr_conflict_r <= 1'b0;
            rvalid_r      <= '0;
            for (int r = 0; r < n_read; r++) begin
                rdata_r[r] <= '0;
            end
            for (int a = 0; a < depth; a++) begin
                lvt_r[a] <= '0;
            end
        end else begin
            case (state_r)
                ST_INIT: begin
                    lvt_r[init_cnt_r] <= '0;
                    rvalid_r          <= '0;
                    wr_conflict_r     <= 1'b0;
                    if (init_cnt_r == {index_width{1'b1}}) begin
                        state_r     <= ST_RUN;
                        init_done_r <= 1'b1;
                    end else begin
                        init_cnt_r  <= init_cnt_r + {{(index_width-1){1'b0}}, 1'b1};
                    end
                end
                ST_RUN: begin
                    for (int w = 0; w < n_write; w++) begin
                        if (wen_eff_s[w]) begin
                            lvt_r[waddr_s[w]] <= lvt_width'(w);
                        end
                    end
                    for (int r = 0; r < n_read; r++) begin
                        if (ren[r]) begin
                            rdata_r[r] <= rd_word_s[r];
                        end
                    end
                    rvalid_r      <= ren;
                    wr_conflict_r <= conflict_s;
                end
                default: begin
                    state_r    <= ST_INIT;
                    init_cnt_r <= '0;
                end
            endcase
        end
    end

    // Bank storage is deliberately unreset; the INIT sweep clears it instead
    always_ff @(posedge clk) begin
        if (state_r == ST_INIT) begin
            for (int w = 0; w < n_write; w++) begin
                for (int r = 0; r < n_read; r++) begin
                    bank_r[w][r][init_cnt_r] <= '0;
                end
            end
        end else begin
            for (int w = 0; w < n_write; w++) begin
                if (wen_eff_s[w]) begin
                    for (int r = 0; r < n_read; r++) begin
                        bank_r[w][r][waddr_s[w]] <= wdata_s[w];
                    end
                end
            end
        end
    end

    // Pack registered read data onto the flat output bus
    always_comb begin
        for (int r = 0; r < n_read; r++) begin
            rdata[r*data_width +: data_width] = rdata_r[r];
        end
    end

    assign rvalid      = rvalid_r;
    assign init_done   = init_done_r;
    assign wr_conflict = wr_conflict_r;

endmodule

// File: tb/tb_lvt_multiport_ram.sv
// Directed table-driven bench for lvt_multiport_ram (default 2W/2R, 32-bit, 64 entries).
module tb_lvt_multiport_ram;

    localparam int IW = 6;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      wen;
    logic [2*IW-1:0] waddr;
    logic [2*DW-1:0] wdata;
    logic [1:0]      ren;
    logic [2*IW-1:0] raddr;
    logic [2*DW-1:0] rdata;
    logic [1:0]      rvalid;
    logic            init_done;
    logic            wr_conflict;

    int n_vec = 0;
    int n_err = 0;

    lvt_multiport_ram #(
        .n_write(2), .n_read(2), .data_width(DW), .index_width(IW)
    ) dut (
        .clk(clk), .reset(reset), .wen(wen), .waddr(waddr), .wdata(wdata),
        .ren(ren), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
        .init_done(init_done), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wen;
        logic [5:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [1:0]  ren;
        logic [5:0]  ra0, ra1;
        logic [1:0]  xv;
        logic [31:0] xd0, xd1;
        logic        xc;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] w_en, input logic [5:0] wa0, input logic [31:0] wd0,
                                input logic [5:0] wa1, input logic [31:0] wd1,
                                input logic [1:0] r_en, input logic [5:0] ra0, input logic [5:0] ra1,
                                input logic [1:0] xv, input logic [31:0] xd0, input logic [31:0] xd1,
                                input logic xc);
        vec_t v;
        v.wen = w_en; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ren = r_en; v.ra0 = ra0; v.ra1 = ra1;
        v.xv = xv; v.xd0 = xd0; v.xd1 = xd1; v.xc = xc;
        return v;
    endfunction

    task automatic idle_inputs();
        wen = 2'b00; waddr = '0; wdata = '0; ren = 2'b00; raddr = '0;
    endtask

    // Counts edges from reset release until init_done; drives junk traffic that must be ignored
    task automatic wait_init(input string tag);
        int cycles;
        cycles = 0;
        wen = 2'b11; waddr = {6'd5, 6'd5}; wdata = {32'hFFFF_FFFF, 32'hEEEE_EEEE};
        ren = 2'b11; raddr = {6'd1, 6'd2};
        for (int i = 1; i <= 200; i++) begin
            step();
            cycles = i;
            if (init_done) break;
            if (i % 16 == 0) begin
                check({tag, " init rvalid"}, {62'd0, rvalid}, 64'd0);
                check({tag, " init wr_conflict"}, {63'd0, wr_conflict}, 64'd0);
            end
        end
        idle_inputs();
        check({tag, " init cycles"}, 64'(cycles), 64'd64);
    endtask

    initial begin
        logic [31:0] x8;
        reset = 1'b0;
        idle_inputs();
        #12;
        check("reset rdata", rdata, 64'd0);
        check("reset rvalid", {62'd0, rvalid}, 64'd0);
        check("reset init_done", {63'd0, init_done}, 64'd0);
        check("reset wr_conflict", {63'd0, wr_conflict}, 64'd0);
        step();
        step();
        reset = 1'b1;
        wait_init("first");

        // Full read sweep: every entry cleared, both ports, one-cycle latency
        for (int a = 0; a < 64; a++) begin
            ren = 2'b11;
            raddr = {6'(63 - a), 6'(a)};
            step();
            check($sformatf("sweep a%0d rvalid", a), {62'd0, rvalid}, 64'd3);
            check($sformatf("sweep a%0d rdata", a), rdata, 64'd0);
        end
        idle_inputs();

`ifdef LVT_BYPASS_EN
        x8 = 32'h0000_0033;
`else
        x8 = 32'h0000_0000;
`endif
        //        wen    wa0  wd0            wa1  wd1            ren    ra0  ra1  xv     xd0            xd1            xc
        tbl[0]  = mk(2'b01, 6'd5,  32'hA5A5_0001, 6'd0,  32'h0,         2'b00, 6'd0, 6'd0, 2'b00, 32'h0,         32'h0,         1'b0);
        tbl[1]  = mk(2'b00, 6'd0,  32'h0,         6'd0,  32'h0,         2'b10, 6'd0, 6'd5, 2'b10, 32'h0,         32'hA5A5_0001, 1'b0);
        tbl[2]  = mk(2'b01, 6'd7,  32'h1,         6'd0,  32'h0,         2'b00, 6'd0, 6'd0, 2'b00, 32'h0,         32'hA5A5_0001, 1'b0);
        tbl[3]  = mk(2'b10, 6'd0,  32'h0,         6'd7,  32'h2,         2'b00, 6'd0, 6'd0, 2'b00, 32'h0,         32'hA5A5_0001, 1'b0);
        tbl[4]  = mk(2'b00, 6'd0,  32'h0,         6'd0,  32'h0,         2'b11, 6'd7, 6'd7, 2'b11, 32'h2,         32'h2,         1'b0);
        tbl[5]  = mk(2'b11, 6'd9,  32'h11,        6'd9,  32'h22,        2'b00, 6'd0, 6'd0, 2'b00, 32'h2,         32'h2,         1'b1);
        tbl[6]  = mk(2'b00, 6'd0,  32'h0,         6'd0,  32'h0,         2'b00, 6'd0, 6'd0, 2'b00, 32'h2,         32'h2,         1'b0);
        tbl[7]  = mk(2'b00, 6'd0,  32'h0,         6'd0,  32'h0,         2'b11, 6'd9, 6'd9, 2'b11, 32'h11,        32'h11,        1'b0);
        tbl[8]  = mk(2'b10, 6'd0,  32'h0,         6'd3,  32'h33,        2'b01, 6'd3, 6'd0, 2'b01, x8,            32'h11,        1'b0);
        tbl[9]  = mk(2'b00, 6'd0,  32'h0,         6'd0,  32'h0,         2'b11, 6'd3, 6'd5, 2'b11, 32'h33,        32'hA5A5_0001, 1'b0);
        tbl[10] = mk(2'b11, 6'd10, 32'hAAAA,      6'd11, 32'hBBBB,      2'b00, 6'd0, 6'd0, 2'b00, 32'h33,        32'hA5A5_0001, 1'b0);
        tbl[11] = mk(2'b00, 6'd0,  32'h0,         6'd0,  32'h0,         2'b11, 6'd10, 6'd11, 2'b11, 32'hAAAA,    32'hBBBB,      1'b0);
        tbl[12] = mk(2'b10, 6'd0,  32'h0,         6'd12, 32'hC1,        2'b00, 6'd0, 6'd0, 2'b00, 32'hAAAA,      32'hBBBB,      1'b0);
        tbl[13] = mk(2'b01, 6'd12, 32'hC0,        6'd0,  32'h0,         2'b00, 6'd0, 6'd0, 2'b00, 32'hAAAA,      32'hBBBB,      1'b0);
        tbl[14] = mk(2'b00, 6'd0,  32'h0,         6'd0,  32'h0,         2'b11, 6'd12, 6'd12, 2'b11, 32'hC0,      32'hC0,        1'b0);

        for (int i = 0; i < 15; i++) begin
            wen   = tbl[i].wen;
            waddr = {tbl[i].wa1, tbl[i].wa0};
            wdata = {tbl[i].wd1, tbl[i].wd0};
            ren   = tbl[i].ren;
            raddr = {tbl[i].ra1, tbl[i].ra0};
            step();
            check($sformatf("v%0d rvalid", i), {62'd0, rvalid}, {62'd0, tbl[i].xv});
            check($sformatf("v%0d rdata0", i), {32'd0, rdata[31:0]}, {32'd0, tbl[i].xd0});
            check($sformatf("v%0d rdata1", i), {32'd0, rdata[63:32]}, {32'd0, tbl[i].xd1});
            check($sformatf("v%0d wr_conflict", i), {63'd0, wr_conflict}, {63'd0, tbl[i].xc});
        end
        idle_inputs();

        // Asynchronous reset drops an in-flight read immediately
        ren = 2'b01; raddr = {6'd0, 6'd5};
        step();
        check("pre-reset rvalid", {62'd0, rvalid}, 64'd1);
        idle_inputs();
        reset = 1'b0;
        #1;
        check("async reset rvalid", {62'd0, rvalid}, 64'd0);
        check("async reset init_done", {63'd0, init_done}, 64'd0);
        check("async reset rdata", rdata, 64'd0);
        step();
        reset = 1'b1;

        // Interrupt the sweep at init_cnt==20 and confirm it restarts from zero
        for (int i = 0; i < 20; i++) step();
        check("mid-init init_done", {63'd0, init_done}, 64'd0);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        wait_init("restart");

        ren = 2'b11; raddr = {6'd12, 6'd5};
        step();
        check("post-restart rvalid", {62'd0, rvalid}, 64'd3);
        check("post-restart rdata", rdata, 64'd0);
        idle_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lvt_multiport_ram.md
Name: lvt_multiport_ram

Overview:
Parametrised multi-write, multi-read RAM built from a register-based Live Value Table (LVT) and replicated banks. Each write port owns one bank per read port. The LVT records which write port last wrote each address, and the read mux uses it to pick the live bank. It is the storage core for the hash table: `n_write` PE write ports and `n_read` lookup ports, with a built-in post-reset clear sequence.

Parameters:
- n_write, 2, number of write ports (≥1)
- n_read, 2, number of read ports (≥1)
- data_width, 32, bits per entry (key+value word)
- index_width, 6, address bits; depth = 2^index_width
- lvt_width, max(1,$clog2(n_write)), LVT entry width (derived, localparam)

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  asynchronous, active-low reset
- wen  in  n_write  per-port write enable
- waddr  in  n_write*index_width  flat write addresses, port w at [w*index_width+:index_width]
- wdata  in  n_write*data_width  flat write data
- ren  in  n_read  per-port read enable
- raddr  in  n_read*index_width  flat read addresses
- rdata  out  n_read*data_width  flat read data, registered
- rvalid  out  n_read  rdata[r] valid this cycle
- init_done  out  1  high once clear sweep finished
- wr_conflict  out  1  one-cycle pulse: same-address write collision occurred previous cycle

Behaviour:
- Storage: n_write*n_read banks, bank[w][r] of depth 2^index_width x data_width.
  - Bank[w][r] is written only by write port w and read only by read port r.
  - LVT holds 2^index_width x lvt_width entries.
- Reset (reset==0, asynchronous):
  - LVT entries = 0; rdata = 0; rvalid = 0; init_done = 0; wr_conflict = 0.
  - FSM = INIT, init counter = 0.
  - Bank contents are not reset.
- FSM:
  - INIT: each cycle writes 0 to address `init_cnt` in every bank and sets LVT[init_cnt] = 0. The counter increments.
  - INIT → RUN after address depth-1 is written. init_done goes high on the next edge; exactly 2^index_width cycles after reset deasserts.
  - During INIT, wen/ren are ignored, rvalid stays 0, and wr_conflict stays 0.
  - RUN is held until reset. There is no other exit.
- Write (RUN):
  - If wen[w] is high, wdata[w] is written to bank[w][0..n_read-1] at waddr[w], and LVT[waddr[w]] <= w, on the same edge.
  - Collision: two or more enabled ports with equal waddr in one cycle. The lowest-index port wins and the other colliding ports' bank writes are suppressed.
  - wr_conflict = 1 on the following cycle only.
  - Non-colliding ports proceed normally in the same cycle.
- Read (RUN):
  - ren[r] high at edge t: LVT[raddr[r]] and bank[*][r][raddr[r]] are sampled at t.
  - rdata[r] = bank[sel][r] is presented after edge t, so read latency is 1 cycle, with rvalid[r] = 1 for that one cycle.
  - Reads are read-before-write: a write landing on edge t is not visible to a read sampled at t (unless LVT_BYPASS_EN).
- ren[r] low: rvalid[r] = 0 next cycle, rdata[r] holds its last value.
- All read ports are independent. Any number of read ports may read the same address simultaneously.
- n_write==1: LVT is constant 0 and the mux degenerates; behaviour is otherwise identical.
- Address wrap: no arithmetic on addresses. The init counter is exactly index_width bits and stops at depth-1.
- Reset mid-operation: all in-flight reads are dropped (rvalid=0), the FSM returns to INIT, and the sweep restarts from address 0.

Optional Feature:
Macro `LVT_BYPASS_EN`.
- Defined: each read port compares raddr[r] against every enabled write port in the same cycle. On a match, rdata[r] next cycle is the winning (lowest-index) write's wdata, giving write-to-read forwarding.
- Undefined: no comparators; reads return pre-write data as specified above.
- LVT, collision and init behaviour are unchanged either way.

Test Plan:
- Defaults; release reset → init_done rises exactly 64 cycles later. Read addresses 0..63 on both ports → all rdata=0x00000000, rvalid=1 one cycle after each ren.
- Port0 writes addr 5 = 0xA5A50001; next cycle port1 reads addr 5 → rdata[1]=0xA5A50001 one cycle after ren.
- Port0 writes addr 7 = 0x1, later port1 writes addr 7 = 0x2; then read addr 7 on both read ports → both return 0x2 (LVT selects bank 1).
- Same cycle, port0 writes addr 9 = 0x11 and port1 writes addr 9 = 0x22 → wr_conflict=1 for exactly one cycle; subsequent read of addr 9 → 0x11.
- Addr 3 holds 0x0; same cycle, port1 writes addr 3 = 0x33 and read port0 reads addr 3 → next cycle rdata[0]=0x0 without `LVT_BYPASS_EN`, 0x33 with it.
- Assert reset when init_cnt=20, release → init_done=0, sweep restarts at 0, init_done rises 64 cycles after release; pending rvalid cleared immediately.
